// File: rtl/mul_acc_if.sv
// -----------------------------------------------------------------------------
// mul_acc_if
//
// Handshake and operand bundle for the sequential multiply-accumulate unit.
// The signal set matches the sequential divider's so one controller can drive
// both units.
//
//   start  master -> slave  one-cycle pulse; captures a, b, c and begins
//   a      master -> slave  multiplicand, sampled on the start edge
//   b      master -> slave  multiplier, sampled on the start edge
//   c      master -> slave  addend, sampled on the start edge
//   busy   slave -> master  operation in progress
//   valid  slave -> master  p holds a completed result
//   p      slave -> master  result a*b + c, 2*WIDTH bits
//
// The master modport is the controller side and the slave modport is the
// arithmetic unit side.
// -----------------------------------------------------------------------------
interface mul_acc_if #(
  parameter int WIDTH = 4
) ();

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       c;
  logic                   busy;
  logic                   valid;
  logic [2*WIDTH-1:0]     p;

  modport master (
    output start,
    output a,
    output b,
    output c,
    input  busy,
    input  valid,
    input  p
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  c,
    output busy,
    output valid,
    output p
  );

endinterface : mul_acc_if

// File: rtl/mul_acc.sv
// -----------------------------------------------------------------------------
// mul_acc
//
// Sequential unsigned multiply-accumulate: p = a*b + c, computed one
// multiplier bit per clock with shift-and-add. It is the inverse of the
// sequential divider; feeding back (a=q, b=y, c=r) reconstructs the dividend.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; aborts any operation in flight
//   bus   mul_acc_if.slave
//           start/a/b/c in, busy/valid/p out (see mul_acc_if)
//
// Timing
//   The start edge E0 captures the operands and raises busy. The unit then
//   spends exactly WIDTH edges in RUN; on E(WIDTH) busy drops, valid rises
//   and p is loaded. p and valid hold until the next start or reset.
//   A start in any state (including the completing edge) restarts the unit
//   with the new operands and suppresses the old result.
// -----------------------------------------------------------------------------
module mul_acc #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  mul_acc_if.slave     bus
);

  // Counter wide enough to hold WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   I_LAST = CW'(WIDTH - 1);

  // DONE is not a state of its own: it is IDLE with valid_q set.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;

  // Datapath registers. {hi_q, lo_q} is the shifting accumulator: lo_q starts
  // as the multiplier and is consumed from bit 0 while product bits fill in
  // from the top.
  logic [WIDTH-1:0]     a_q,  a_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        i_q,  i_d;
  logic [2*WIDTH-1:0]   p_q,  p_d;
  logic                 valid_q, valid_d;

  // One shift-and-add step, computed from the current accumulator.
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     hi_step;
  logic [WIDTH-1:0]     lo_step;
  logic                 last_step;

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  // NOTE: every flop is updated with <= so all registers sample the values
  // that existed before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      i_q     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      i_q     <= i_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-and-add step
  // ---------------------------------------------------------------------------
  // The addend c is preloaded into hi_q on the start edge. Each step shifts the
  // whole accumulator right once, so after WIDTH steps c has moved down into
  // the low half: the final {hi, lo} equals a*b + c exactly. hi_q + a_q can
  // reach 2^(W+1)-2, hence the WIDTH+1 bit adder; the carry is shifted back
  // into the top of hi on the same step.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally, elsewhere via defaults) so no latch is inferred.
  always_comb begin
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    hi_step   = sum[WIDTH:1];
    lo_step   = {sum[0], lo_q[WIDTH-1:1]};
    last_step = (i_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // start has priority over everything, including the completing edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.start)      state_d = RUN;
        else if (last_step) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    i_d     = i_q;
    p_d     = p_q;
    valid_d = valid_q;

    if (bus.start) begin
      // Capture operands and (re)start; any previous or in-flight result is
      // withdrawn. p itself keeps its old value until the new one lands.
      a_d     = bus.a;
      hi_d    = bus.c;
      lo_d    = bus.b;
      i_d     = I_LAST;
      valid_d = 1'b0;
    end else if (state_q == RUN) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (last_step) begin
        valid_d = 1'b1;
        p_d     = {hi_step, lo_step};
      end else begin
        i_d = i_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.valid = valid_q;
    bus.p     = p_q;
  end

endmodule : mul_acc

// File: tb/tb_mul_acc.sv
// -----------------------------------------------------------------------------
// tb_mul_acc
//
// Self-checking bench for mul_acc at WIDTH=4. Expected results come from
// plain integer arithmetic (a*b + c, or the dividend for divider round trips);
// expected timing comes from the start/busy/valid contract: busy on the start
// edge, valid and p exactly WIDTH edges later, p holding its previous value
// while running. Inputs are driven on the falling edge, outputs are sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mul_acc;

  localparam int W = 4;

  logic clk;
  logic rst;

  mul_acc_if #(.WIDTH(W)) bus ();

  mul_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference for the held result: last completed value, 0 after reset.
  int prev_p = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present operands with start on the falling edge, let the rising edge E0
  // sample them, then drop start and scramble the operand inputs so any late
  // sampling would show up as a wrong result. Returns at E0 + 1 ns.
  task automatic start_pulse(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic [W-1:0] tc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.c     = tc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.c     = W'($urandom);
  endtask

  // Called at E0 + 1 ns: checks busy/valid/p at E0..E(W) and the result.
  task automatic wait_result(input int e, input string tag);
    check({tag, " busy@E0"},  32'(bus.busy),  32'd1);
    check({tag, " valid@E0"}, 32'(bus.valid), 32'd0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      if (k < W) begin
        check({tag, " busy run"},  32'(bus.busy),  32'd1);
        check({tag, " valid run"}, 32'(bus.valid), 32'd0);
        check({tag, " p held"},    32'(bus.p),     32'(prev_p));
      end else begin
        check({tag, " busy done"},  32'(bus.busy),  32'd0);
        check({tag, " valid done"}, 32'(bus.valid), 32'd1);
        check({tag, " p"},          32'(bus.p),     32'(e));
      end
    end
    prev_p = e;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] tc, input int e, input string tag);
    start_pulse(ta, tb_v, tc);
    wait_result(e, tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;

    // Reset state.
    #12;
    check("reset busy",  32'(bus.busy),  32'd0);
    check("reset valid", 32'(bus.valid), 32'd0);
    check("reset p",     32'(bus.p),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle busy", 32'(bus.busy), 32'd0);

    // Directed cases.
    run_op(4'd7,  4'd3,  4'd2,  23,  "7*3+2");
    run_op(4'd15, 4'd15, 4'd15, 240, "15*15+15");
    run_op(4'd9,  4'd0,  4'd5,  5,   "9*0+5");
    run_op(4'd0,  4'd11, 4'd0,  0,   "0*11+0");

    // Result holds while idle.
    run_op(4'd6, 4'd5, 4'd1, 31, "hold op");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold valid", 32'(bus.valid), 32'd1);
      check("hold busy",  32'(bus.busy),  32'd0);
      check("hold p",     32'(bus.p),     32'd31);
    end

    // Divider round trip: a=x/y, b=y, c=x%y must rebuild x.
    for (int x = 0; x < (1 << W); x++) begin
      for (int y = 1; y < (1 << W); y++) begin
        run_op(W'(x / y), W'(y), W'(x % y), x, "roundtrip");
      end
    end

    // Random operands against a*b + c.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      run_op(ra, rb, rc, int'(ra) * int'(rb) + int'(rc), "random");
    end

    // Restart while busy: the 5*5 result must never appear.
    start_pulse(4'd5, 4'd5, 4'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort valid", 32'(bus.valid), 32'd0);
      check("abort p",     32'(bus.p),     32'(prev_p));
    end
    start_pulse(4'd2, 4'd6, 4'd1);
    wait_result(13, "restart");

    // Start on the completing edge: start wins, no valid for the first op.
    start_pulse(4'd3, 4'd3, 4'd3);
    repeat (W - 1) @(posedge clk);
    start_pulse(4'd4, 4'd4, 4'd4);
    check("collide valid", 32'(bus.valid), 32'd0);
    check("collide p",     32'(bus.p),     32'(prev_p));
    wait_result(20, "collide");

    // Asynchronous reset between edges mid-run.
    start_pulse(4'd9, 4'd9, 4'd9);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst busy",  32'(bus.busy),  32'd0);
    check("async rst valid", 32'(bus.valid), 32'd0);
    check("async rst p",     32'(bus.p),     32'd0);
    prev_p = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post rst valid", 32'(bus.valid), 32'd0);
    run_op(4'd6, 4'd7, 4'd3, 45, "after rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: the stimulus is a fixed sequence, so this only trips on a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule : tb_mul_acc
